// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 key-schedule types, Rcon table, S-box table
//               and word helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int NR = 10;

    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    // Byte x of the S-box sits at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
        logic [10:0] lsb;
        lsb = 11'd2040 - {x, 3'b000};
        return SBOX_TABLE[lsb +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
                sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
    endfunction

endpackage : aes_pkg
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational 8-bit AES forward S-box.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    assign o_byte = sbox_lookup(i_byte);

endmodule : aes_sbox
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule
// Description : AES-128 decryption key scheduler; expands forward to round 10
//               then streams round keys 10..0 using the inverse recurrence.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         done
);
    import aes_pkg::*;

    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    state_t     r_state, w_state_nxt;
    round_key_t r_key,   w_key_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;
    logic       r_done,  w_done_nxt;

    logic [31:0] w_a, w_b, w_c, w_d, w_dc;
    logic [31:0] w_sw_in, w_sw_out, w_t;
    logic [31:0] w_fa, w_fb, w_fc, w_fd;
    logic [7:0]  w_rcon;
    round_key_t  w_key_fwd, w_key_bwd;

    assign w_a  = r_key[127:96];
    assign w_b  = r_key[95:64];
    assign w_c  = r_key[63:32];
    assign w_d  = r_key[31:0];
    assign w_dc = w_d ^ w_c;

    // The single SubWord is shared: d when expanding, the recovered d' when streaming.
    assign w_sw_in = (r_state == ST_OUT) ? rot_word(w_dc) : rot_word(w_d);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_sw_in[8*gi +: 8]),
                .o_byte (w_sw_out[8*gi +: 8])
            );
        end
    endgenerate

    assign w_rcon = (r_state == ST_OUT) ? rcon(r_cnt) : rcon(r_cnt + 4'd1);
    assign w_t    = w_sw_out ^ {w_rcon, 24'h0};

    assign w_fa      = w_a ^ w_t;
    assign w_fb      = w_b ^ w_fa;
    assign w_fc      = w_c ^ w_fb;
    assign w_fd      = w_d ^ w_fc;
    assign w_key_fwd = {w_fa, w_fb, w_fc, w_fd};
    assign w_key_bwd = {w_a ^ w_t, w_b ^ w_a, w_c ^ w_b, w_dc};

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (key_load) begin
            // A new key restarts from any state and pre-empts a pending handshake.
            w_state_nxt = ST_EXPAND;
            w_key_nxt   = key_in;
            w_cnt_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_EXPAND: begin
                    w_key_nxt = w_key_fwd;
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (r_cnt + 4'd1 == c_LAST_ROUND) begin
                        w_state_nxt = ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (rk_ready) begin
                        if (r_cnt != 4'd0) begin
                            w_key_nxt = w_key_bwd;
                            w_cnt_nxt = r_cnt - 4'd1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_cnt   <= 4'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy     = (r_state == ST_EXPAND);
    assign rk_valid = (r_state == ST_OUT);
    assign rk_out   = r_key;
    assign rk_idx   = r_cnt;
    assign done     = r_done;

endmodule : aes_inv_key_schedule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_schedule
// Description : Self-checking bench against a table-free AES key expansion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n, key_load, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_m [0:255];
    logic [127:0] exp_rk [0:10];
    logic [127:0] obs_rk [0:10];

    always #5 clk = ~clk;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_load (key_load),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (v != 0)
                for (int c = 1; c < 256; c++)
                    if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        key_in   = rand128();
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({busy, rk_valid, done, rk_idx, rk_out} !== '0) begin
            n_err++;
            $display("FAIL %s: got busy=%b valid=%b done=%b idx=%0d rk=%h want all zero",
                     name, busy, rk_valid, done, rk_idx, rk_out);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if ({busy, rk_valid, done} !== 3'b000) begin
            n_err++;
            $display("FAIL %s: got busy=%b valid=%b done=%b want 000", name, busy, rk_valid, done);
        end
    endtask

    task automatic wait_valid(input string name);
        int g;
        g = 0;
        while (rk_valid !== 1'b1 && g < 40) begin tick(); g++; end
        n_cmp++;
        if (rk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got rk_valid=%b want 1 within 40 cycles", name, rk_valid);
        end
    endtask

    // Loads k and consumes the full stream with stall_pct percent of cycles not ready.
    task automatic run_stream(input logic [127:0] k, input int stall_pct);
        int edges, bad, hs, guard, exp_idx;
        model_expand(k);
        load_key(k);
        edges = 1; bad = 0;
        while (rk_valid !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            tick();
            edges++;
        end
        if (busy !== 1'b0) bad++;
        n_cmp++;
        if (edges != 11) begin
            n_err++;
            $display("FAIL latency: got valid at edge %0d want 11", edges);
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL busy_window: got %0d bad cycles want 0", bad);
        end
        exp_idx = 10; hs = 0; guard = 0;
        while (hs < 11 && guard < 500 && rk_valid === 1'b1) begin
            guard++;
            rk_ready = ($urandom_range(0, 99) >= stall_pct);
            n_cmp++;
            if (rk_idx !== 4'(exp_idx) || rk_out !== exp_rk[exp_idx] || done !== 1'b0) begin
                n_err++;
                $display("FAIL stream_key: got idx=%0d rk=%h done=%b want idx=%0d rk=%h done=0",
                         rk_idx, rk_out, done, exp_idx, exp_rk[exp_idx]);
            end
            if (rk_ready) begin
                obs_rk[exp_idx] = rk_out;
                hs++;
                tick();
                if (exp_idx == 0) begin
                    n_cmp++;
                    if (done !== 1'b1 || rk_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL done_pulse: got done=%b valid=%b want done=1 valid=0",
                                 done, rk_valid);
                    end
                end else begin
                    exp_idx--;
                end
            end else begin
                tick();
            end
        end
        rk_ready = 1'b0;
        n_cmp++;
        if (hs != 11) begin
            n_err++;
            $display("FAIL handshakes: got %0d want 11", hs);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || rk_valid !== 1'b0 || rk_out !== k) begin
            n_err++;
            $display("FAIL after_done: got done=%b valid=%b rk=%h want done=0 valid=0 rk=%h",
                     done, rk_valid, rk_out, k);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; key_load = 1'b1; key_in = rand128(); rk_ready = 1'b1;
        tick();
        check_zero("reset_state");
        tick();
        rst_n = 1'b1; key_load = 1'b0; rk_ready = 1'b0;
        tick();
        check_idle("reset_ignores_load");
    endtask

    task automatic test_fips_vector();
        run_stream(128'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        n_cmp++;
        if (obs_rk[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_err++; $display("FAIL fips_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_rk[10]);
        end
        n_cmp++;
        if (obs_rk[9] !== 128'hac7766f319fadc2128d12941575c006e) begin
            n_err++; $display("FAIL fips_rk9: got %h want ac7766f319fadc2128d12941575c006e", obs_rk[9]);
        end
        n_cmp++;
        if (obs_rk[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_err++; $display("FAIL fips_rk1: got %h want a0fafe1788542cb123a339392a6c7605", obs_rk[1]);
        end
        n_cmp++;
        if (obs_rk[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            n_err++; $display("FAIL fips_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", obs_rk[0]);
        end
    endtask

    task automatic test_zero_key();
        run_stream(128'h0, 0);
        n_cmp++;
        if (obs_rk[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            n_err++; $display("FAIL zero_rk10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", obs_rk[10]);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) run_stream(rand128(), 50);
    endtask

    task automatic test_abort_expand();
        int seen_done;
        seen_done = 0;
        load_key(rand128());
        for (int i = 0; i < 5; i++) begin
            if (done !== 1'b0) seen_done++;
            tick();
        end
        n_cmp++;
        if (busy !== 1'b1 || seen_done != 0) begin
            n_err++;
            $display("FAIL abort_expand_pre: got busy=%b done_count=%0d want busy=1 done_count=0",
                     busy, seen_done);
        end
        run_stream(rand128(), 20);
    endtask

    task automatic test_abort_out();
        int g;
        load_key(rand128());
        wait_valid("abort_out_valid");
        rk_ready = 1'b1;
        g = 0;
        while (rk_idx !== 4'd4 && g < 20) begin tick(); g++; end
        n_cmp++;
        if (rk_idx !== 4'd4 || rk_valid !== 1'b1) begin
            n_err++;
            $display("FAIL abort_out_reach: got idx=%0d valid=%b want idx=4 valid=1", rk_idx, rk_valid);
        end
        // rk_ready stays high on the reload edge; key_load must win.
        run_stream(rand128(), 30);
    endtask

    task automatic test_reset_mid();
        load_key(rand128());
        tick(); tick(); tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL mid_expand_busy: got %b want 1", busy);
        end
        rst_n = 1'b0; key_load = 1'b1;
        tick();
        check_zero("reset_mid_expand");
        rst_n = 1'b1; key_load = 1'b0;
        tick();
        check_idle("idle_after_reset_expand");

        load_key(rand128());
        wait_valid("reset_mid_out_valid");
        rk_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b0; key_load = 1'b1;
        tick();
        check_zero("reset_mid_out");
        rst_n = 1'b1; key_load = 1'b0; rk_ready = 1'b0;
        tick();
        check_idle("idle_after_reset_out");
    endtask

    initial begin
        rst_n = 1'b0; key_load = 1'b0; rk_ready = 1'b0; key_in = '0;
        build_sbox();
        test_reset();
        test_fips_vector();
        test_zero_key();
        test_backpressure();
        test_abort_expand();
        test_abort_out();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aes_inv_key_schedule
`default_nettype wire

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Sequential AES-128 decryption-side key scheduler.
- On a key load it first runs the forward expansion, one round key per cycle, to reach round key 10.
- It then streams round keys 10, 9, …, 0 over a valid/ready handshake, recomputing each previous key on the fly with the inverse recurrence. No 44-word table is stored.
- It feeds the inverse-cipher datapath, which consumes round keys in reverse order.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported, other values are illegal.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low, sampled on rising edge of clk
key_in  in  128  cipher key; key_in[127:96] is word w0, key_in[31:0] is w3
key_load  in  1  one-cycle strobe; captures key_in and starts expansion
busy  out  1  high while forward expansion runs
rk_valid  out  1  rk_out/rk_idx hold a valid round key
rk_ready  in  1  consumer accepts the current round key
rk_out  out  128  round key words {w[4r], w[4r+1], w[4r+2], w[4r+3]}
rk_idx  out  4  round number r of rk_out (10 down to 0)
done  out  1  one-cycle pulse when round key 0 is accepted

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0, internal key register=0. Reset overrides key_load.
- Word functions:
  - RotWord moves the most-significant byte to the least-significant position.
  - SubWord applies the AES S-box to each byte.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, XORed into bits [31:24] only.
- Forward step (r-1 → r), with current key {a,b,c,d}:
  - t = SubWord(RotWord(d)) ^ {Rcon[r],24'h0}
  - a' = a^t, b' = b^a', c' = c^b', d' = d^c'
- Backward step (r → r-1):
  - d' = d^c, c' = c^b, b' = b^a
  - a' = a ^ SubWord(RotWord(d')) ^ {Rcon[r],24'h0}
- Exactly one SubWord instance (4 S-boxes). Its input is muxed: d in EXPAND, d^c in OUT. Each step is one cycle.
- FSM states: IDLE, EXPAND, OUT.
  - IDLE: rk_valid=0, busy=0. On key_load: load key register with key_in, cnt=0, go to EXPAND.
  - EXPAND: busy=1. Each edge applies the forward step with Rcon[cnt+1] and increments cnt. On the edge where cnt reaches 10: go to OUT, rk_valid=1, rk_idx=10, rk_out=round key 10, busy=0.
  - Latency: rk_valid rises on the 11th rising edge counting the key_load sampling edge as edge 1.
  - OUT: rk_out/rk_idx are held stable while rk_valid=1 and rk_ready=0.
    - On rk_valid&rk_ready with rk_idx>0: next edge presents round key rk_idx-1 (backward step with Rcon[rk_idx]); rk_valid stays 1. A fully ready consumer receives one key per cycle.
    - On rk_valid&rk_ready with rk_idx=0: next edge rk_valid=0, done=1 for one cycle, state=IDLE. rk_out keeps round key 0 (equal to the loaded key).
- key_load in EXPAND or OUT aborts the current operation and restarts with the new key_in. It has priority over rk_ready; no done pulse is generated.
- key_in is only sampled on the key_load edge and may change freely afterwards.
- rk_ready is ignored when rk_valid=0.

Decomposition:
- Package aes_pkg:
  - NR, RCON table function (round number → byte)
  - sub_word/rot_word helpers
  - 128-bit round_key_t typedef
- Sub-module aes_sbox: combinational 8-bit S-box, instantiated 4× for SubWord.
- FSM, counter and forward/backward step logic live in aes_inv_key_schedule.

Test Plan:
- Load key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - busy for 10 cycles, then rk_idx=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6
  - next cycle rk_idx=9, rk_out=ac7766f319fadc2128d12941575c006e
  - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605; rk_idx=0 returns the key
  - done pulses once.
- Load all-zero key: rk_idx=10 must show b4ef5bcb3e92e21123e951cf6f8f188e. Full reverse stream ends at 0 and matches a forward software model.
- Backpressure: random rk_ready gaps in OUT → rk_out/rk_idx stable while stalled; exactly 11 handshakes; done after the idx 0 handshake.
- key_load at cnt=5 in EXPAND, and again at rk_idx=4 in OUT, with a new key → stream restarts from round 10 of the new key; no done pulse for the aborted run.
- rst_n=0 mid-EXPAND and mid-OUT → next edge all outputs zero, state IDLE. key_load asserted simultaneously with rst_n=0 is ignored.
